sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter SRAM_DEPTH, default 128, number of 32-bit words in the attached SRAM; legal addresses are 0..SRAM_DEPTH-1.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, synchronous and active-high.
REQ-004 REQ0, REQ1  input  1 each  access request from requester 0 / 1; held high until the matching ACK.
REQ-005 WR0, WR1  input  1 each  1 = write, 0 = read; sampled with the request.
REQ-006 ADDR0, ADDR1  input  32 each  word address; sampled with the request.
REQ-007 WDATA0, WDATA1  input  32 each  write data; sampled with the request.
REQ-008 GNT0, GNT1  output  1 each  high during the ACCESS cycle of that requester.
REQ-009 ACK0, ACK1  output  1 each  one-cycle completion pulse.
REQ-010 ERR0, ERR1  output  1 each  valid with ACK; 1 = address out of range, no SRAM access made.
REQ-011 RDATA  output  32  read data; valid in the ACK cycle of a read.
REQ-012 SRAM_WE, SRAM_RE  output  1 each  SRAM write and read enables.
REQ-013 SRAM_ADDRESS, SRAM_WD  output  32 each  SRAM address and write data.
REQ-014 SRAM_RA  input  32  SRAM read data, combinational from SRAM_ADDRESS while SRAM_RE=1.

Function
REQ-015 FSM states: IDLE, ACCESS, RESP; IDLE->ACCESS when any REQ high; ACCESS->RESP always; RESP->IDLE always.
REQ-016 Requests are sampled only in IDLE; REQ levels during ACCESS and RESP are ignored.
REQ-017 On leaving IDLE, the winner's WR/ADDR/WDATA are latched; later input changes have no effect on the access.
REQ-018 Arbitration: one requester alone wins; both requesting -> the port not served last wins (round-robin); LAST pointer updates on each grant.
REQ-019 In ACCESS, when the latched address is in range: SRAM_ADDRESS = latched address; write -> SRAM_WE=1, SRAM_RE=0, SRAM_WD = latched data; read -> SRAM_RE=1, SRAM_WE=0.
REQ-020 In ACCESS, when the latched address is >= SRAM_DEPTH: SRAM_WE=0 and SRAM_RE=0.
REQ-021 All SRAM_* outputs are registered; outside ACCESS they are 0, and SRAM_WE and SRAM_RE are never high together.
REQ-022 A read captures SRAM_RA into RDATA at the end of ACCESS; RDATA holds its value until the next read completes; writes and errors leave RDATA unchanged.
REQ-023 In RESP, the ACK of the served port is 1 for exactly one cycle; its ERR equals the range result; the other port's ACK and ERR stay 0.
REQ-024 Latency: request sampled at edge t -> GNT high in cycle t+1 -> ACK in cycle t+2; peak throughput is one access per 3 cycles.
REQ-025 A requester that holds REQ through its ACK cycle is sampled again in the following IDLE cycle and re-arbitrated.
REQ-026 Address comparison uses all 32 bits (unsigned); no wrap-around or truncation.

Reset
REQ-027 With RST high at an edge: state=IDLE, LAST=1 (port 0 wins the first contention), GNT/ACK/ERR=0, SRAM_WE/RE=0, SRAM_ADDRESS/WD=0, RDATA=0.
REQ-028 RST during ACCESS or RESP aborts the transaction with no ACK; a write whose ACCESS cycle coincides with the reset edge commits to the SRAM, because the SRAM samples SRAM_WE at that edge.
REQ-029 RST takes priority over all other inputs.

Verification
REQ-030 Single read: REQ0=1, WR0=0, ADDR0=5 with the SRAM preloaded at word 5 = 5 -> GNT0 in the next cycle with SRAM_RE=1 and SRAM_ADDRESS=5, then ACK0=1, ERR0=0, RDATA=5.
REQ-031 Write then read: port1 writes 0xDEADBEEF to address 10, then reads address 10 -> the read returns RDATA=0xDEADBEEF, and SRAM_WE is high for exactly one cycle.
REQ-032 Contention: REQ0 and REQ1 both held high after reset -> grant order 0,1,0,1; each ACK spaced 3 cycles apart.
REQ-033 Out of range: REQ0 write to address 128 -> no SRAM_WE/RE pulse, then ACK0=1 and ERR0=1; RDATA unchanged.
REQ-034 Reset mid-access: RST asserted in the ACCESS cycle of a read -> no ACK, all outputs 0 next cycle, and the next request is served normally.
REQ-035 Input change after grant: ADDR0 changed during ACCESS -> SRAM_ADDRESS keeps the originally latched address.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// Requester and SRAM bus bundle for sram_arbiter.
// The slave modport is the arbiter's view; master is the requester/SRAM side.
interface sram_arbiter_if;
  logic        req0, req1;
  logic        wr0, wr1;
  logic [31:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1;
  logic        ack0, ack1;
  logic        err0, err1;
  logic [31:0] rdata;
  logic        sram_we, sram_re;
  logic [31:0] sram_address, sram_wd;
  logic [31:0] sram_ra;

  modport slave (
    input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, sram_ra,
    output gnt0, gnt1, ack0, ack1, err0, err1, rdata,
    output sram_we, sram_re, sram_address, sram_wd
  );

  modport master (
    output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, sram_ra,
    input  gnt0, gnt1, ack0, ack1, err0, err1, rdata,
    input  sram_we, sram_re, sram_address, sram_wd
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter in front of a single-port SRAM.
// Each access takes IDLE -> ACCESS -> RESP; all outputs are registered.
module sram_arbiter #(
  parameter int unsigned SRAM_DEPTH = 128
) (
  input  logic          CLK,
  input  logic          RST,
  sram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  localparam logic [31:0] DEPTH_W = 32'(SRAM_DEPTH);

  state_t      state_r, state_s;
  logic        last_r, last_s, sel_r, sel_s, wr_r, wr_s, oor_r, oor_s;
  logic        gnt0_r, gnt0_s, gnt1_r, gnt1_s;
  logic        ack0_r, ack0_s, ack1_r, ack1_s;
  logic        err0_r, err0_s, err1_r, err1_s;
  logic        sram_we_r, sram_we_s, sram_re_r, sram_re_s;
  logic [31:0] sram_address_r, sram_address_s, sram_wd_r, sram_wd_s;
  logic [31:0] rdata_r, rdata_s;
  logic        win_s, win_wr_s, in_range_s;
  logic [31:0] win_addr_s, win_wdata_s;

  // Next-state, arbitration and registered-output decode
  always_comb begin
    state_s        = state_r;
    last_s         = last_r;
    sel_s          = sel_r;
    wr_s           = wr_r;
    oor_s          = oor_r;
    rdata_s        = rdata_r;
    gnt0_s         = 1'b0;
    gnt1_s         = 1'b0;
    ack0_s         = 1'b0;
    ack1_s         = 1'b0;
    err0_s         = 1'b0;
    err1_s         = 1'b0;
    sram_we_s      = 1'b0;
    sram_re_s      = 1'b0;
    sram_address_s = 32'h0000_0000;
    sram_wd_s      = 32'h0000_0000;
    // With both requesting, the port not served last wins
    win_s       = (bus.req0 && bus.req1) ? ~last_r : bus.req1;
    win_wr_s    = win_s ? bus.wr1 : bus.wr0;
    win_addr_s  = win_s ? bus.addr1 : bus.addr0;
    win_wdata_s = win_s ? bus.wdata1 : bus.wdata0;
    in_range_s  = (win_addr_s < DEPTH_W);

    case (state_r)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_s = ACCESS;
          last_s  = win_s;
          sel_s   = win_s;
          wr_s    = win_wr_s;
          oor_s   = ~in_range_s;
          gnt0_s  = ~win_s;
          gnt1_s  = win_s;
          if (in_range_s) begin
            sram_address_s = win_addr_s;
            sram_we_s      = win_wr_s;
            sram_re_s      = ~win_wr_s;
            sram_wd_s      = win_wr_s ? win_wdata_s : 32'h0000_0000;
          end else begin
            sram_address_s = 32'h0000_0000;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        state_s = RESP;
        ack0_s  = ~sel_r;
        ack1_s  = sel_r;
        err0_s  = ~sel_r & oor_r;
        err1_s  = sel_r & oor_r;
        if (!wr_r && !oor_r) begin
          rdata_s = bus.sram_ra;
        end else begin
          rdata_s = rdata_r;
        end
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r        <= IDLE;
      last_r         <= 1'b1;
      sel_r          <= 1'b0;
      wr_r           <= 1'b0;
      oor_r          <= 1'b0;
      gnt0_r         <= 1'b0;
      gnt1_r         <= 1'b0;
      ack0_r         <= 1'b0;
      ack1_r         <= 1'b0;
      err0_r         <= 1'b0;
      err1_r         <= 1'b0;
      sram_we_r      <= 1'b0;
      sram_re_r      <= 1'b0;
      sram_address_r <= 32'h0000_0000;
      sram_wd_r      <= 32'h0000_0000;
      rdata_r        <= 32'h0000_0000;
    end else begin
      state_r        <= state_s;
      last_r         <= last_s;
      sel_r          <= sel_s;
      wr_r           <= wr_s;
      oor_r          <= oor_s;
      gnt0_r         <= gnt0_s;
      gnt1_r         <= gnt1_s;
      ack0_r         <= ack0_s;
      ack1_r         <= ack1_s;
      err0_r         <= err0_s;
      err1_r         <= err1_s;
      sram_we_r      <= sram_we_s;
      sram_re_r      <= sram_re_s;
      sram_address_r <= sram_address_s;
      sram_wd_r      <= sram_wd_s;
      rdata_r        <= rdata_s;
    end
  end

  assign bus.gnt0         = gnt0_r;
  assign bus.gnt1         = gnt1_r;
  assign bus.ack0         = ack0_r;
  assign bus.ack1         = ack1_r;
  assign bus.err0         = err0_r;
  assign bus.err1         = err1_r;
  assign bus.rdata        = rdata_r;
  assign bus.sram_we      = sram_we_r;
  assign bus.sram_re      = sram_re_r;
  assign bus.sram_address = sram_address_r;
  assign bus.sram_wd      = sram_wd_r;
endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: stimulus queues expected grants/acks,
// a monitor pops and compares them whenever the DUT presents GNT or ACK.
module tb_sram_arbiter;
  typedef struct {
    bit          p;
    bit          we;
    bit          re;
    bit          chk_addr;
    logic [31:0] addr;
    logic [31:0] wd;
  } g_t;

  typedef struct {
    bit          p;
    bit          err;
    logic [31:0] rd;
    int          gap;
  } a_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic preload = 1'b1;
  logic chk_reset = 1'b0;
  logic end_chk = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_ack_cyc = 0;
  int   we_cnt = 0;
  g_t   gq[$];
  a_t   aq[$];
  logic [31:0] mem [0:127];

  sram_arbiter_if bus();

  sram_arbiter #(.SRAM_DEPTH(128)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  // SRAM model: synchronous write, combinational read
  always @(posedge CLK) begin
    if (preload) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'(i);
    end else if (bus.sram_we) begin
      mem[bus.sram_address[6:0]] <= bus.sram_wd;
    end
  end
  assign bus.sram_ra = bus.sram_re ? mem[bus.sram_address[6:0]] : 32'h0;

  // Monitor: compare outputs 1 time unit after each rising edge
  always @(posedge CLK) begin
    g_t g;
    a_t a;
    #1;
    cyc = cyc + 1;
    if (chk_reset) begin
      checks++;
      if ({bus.gnt0, bus.gnt1, bus.ack0, bus.ack1, bus.err0, bus.err1, bus.sram_we, bus.sram_re} != 8'h0 ||
          bus.sram_address != 32'h0 || bus.sram_wd != 32'h0 || bus.rdata != 32'h0) begin
        errors++;
        $display("FAIL reset_state: gnt=%b%b ack=%b%b err=%b%b we=%b re=%b addr=%h wd=%h rdata=%h, required all zero",
                 bus.gnt0, bus.gnt1, bus.ack0, bus.ack1, bus.err0, bus.err1, bus.sram_we, bus.sram_re,
                 bus.sram_address, bus.sram_wd, bus.rdata);
      end
    end
    checks++;
    if (bus.gnt0 || bus.gnt1) begin
      if (gq.size() == 0) begin
        errors++;
        $display("FAIL grant_unexpected: gnt0=%b gnt1=%b with no grant expected", bus.gnt0, bus.gnt1);
      end else begin
        g = gq.pop_front();
        if ({bus.gnt1, bus.gnt0, bus.sram_we, bus.sram_re} != {g.p, !g.p, g.we, g.re} ||
            (g.chk_addr && bus.sram_address != g.addr) || bus.sram_wd != g.wd) begin
          errors++;
          $display("FAIL grant: got gnt1/gnt0/we/re=%b%b%b%b addr=%h wd=%h, required %b%b%b%b addr=%h wd=%h",
                   bus.gnt1, bus.gnt0, bus.sram_we, bus.sram_re, bus.sram_address, bus.sram_wd,
                   g.p, !g.p, g.we, g.re, g.addr, g.wd);
        end
      end
    end else if (bus.sram_we || bus.sram_re || bus.sram_address != 32'h0 || bus.sram_wd != 32'h0) begin
      errors++;
      $display("FAIL sram_idle: we=%b re=%b addr=%h wd=%h outside ACCESS, required all zero",
               bus.sram_we, bus.sram_re, bus.sram_address, bus.sram_wd);
    end
    if (bus.ack0 || bus.ack1) begin
      checks++;
      if (aq.size() == 0) begin
        errors++;
        $display("FAIL ack_unexpected: ack0=%b ack1=%b with no ack expected", bus.ack0, bus.ack1);
      end else begin
        a = aq.pop_front();
        if ({bus.ack1, bus.ack0} != {a.p, !a.p} ||
            {bus.err1, bus.err0} != {a.p & a.err, !a.p & a.err} || bus.rdata != a.rd ||
            (a.gap != 0 && (cyc - last_ack_cyc) != a.gap)) begin
          errors++;
          $display("FAIL ack: got ack1/ack0=%b%b err1/err0=%b%b rdata=%h gap=%0d, required %b%b %b%b rdata=%h gap=%0d",
                   bus.ack1, bus.ack0, bus.err1, bus.err0, bus.rdata, cyc - last_ack_cyc,
                   a.p, !a.p, a.p & a.err, !a.p & a.err, a.rd, a.gap);
        end
      end
      last_ack_cyc = cyc;
    end
    if (bus.sram_we) we_cnt++;
    if (end_chk) begin
      checks++;
      if (gq.size() != 0 || aq.size() != 0 || we_cnt != 2) begin
        errors++;
        $display("FAIL drain: pending grants=%0d acks=%0d we_pulses=%0d, required 0 0 2",
                 gq.size(), aq.size(), we_cnt);
      end
    end
  end

  task automatic do_req(input bit p, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input bit e, input logic [31:0] rd, input bit chg);
    g_t g;
    a_t x;
    g.p = p; g.we = w && !e; g.re = !w && !e; g.chk_addr = !e; g.addr = a;
    g.wd = (w && !e) ? d : 32'h0;
    x.p = p; x.err = e; x.rd = rd; x.gap = 0;
    gq.push_back(g);
    aq.push_back(x);
    if (p) begin
      bus.req1 = 1'b1; bus.wr1 = w; bus.addr1 = a; bus.wdata1 = d;
    end else begin
      bus.req0 = 1'b1; bus.wr0 = w; bus.addr0 = a; bus.wdata0 = d;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (chg && bus.gnt0) bus.addr0 = a ^ 32'h0000_000F;
      if (p ? bus.ack1 : bus.ack0) break;
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.wr0 = 1'b0; bus.wr1 = 1'b0;
    bus.addr0 = 32'h0; bus.addr1 = 32'h0; bus.wdata0 = 32'h0; bus.wdata1 = 32'h0;
    @(negedge CLK);
  endtask

  initial begin
    g_t g;
    a_t x;
    int n;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.wr0 = 1'b0; bus.wr1 = 1'b0;
    bus.addr0 = 32'h0; bus.addr1 = 32'h0; bus.wdata0 = 32'h0; bus.wdata1 = 32'h0;
    repeat (3) @(negedge CLK);
    preload = 1'b0;
    chk_reset = 1'b1;
    @(negedge CLK);
    chk_reset = 1'b0;
    RST = 1'b0;

    // Contention after reset: 0,1,0,1 with acks 3 cycles apart
    for (int k = 0; k < 4; k++) begin
      g.p = k[0]; g.we = 1'b0; g.re = 1'b1; g.chk_addr = 1'b1;
      g.addr = k[0] ? 32'd2 : 32'd1; g.wd = 32'h0;
      x.p = k[0]; x.err = 1'b0; x.rd = k[0] ? 32'd2 : 32'd1; x.gap = (k == 0) ? 0 : 3;
      gq.push_back(g);
      aq.push_back(x);
    end
    bus.req0 = 1'b1; bus.req1 = 1'b1; bus.addr0 = 32'd1; bus.addr1 = 32'd2;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (bus.ack0 || bus.ack1) n++;
      if (n == 4) break;
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.addr0 = 32'h0; bus.addr1 = 32'h0;
    @(negedge CLK);

    do_req(1'b0, 1'b0, 32'd5,          32'h0,         1'b0, 32'd5,         1'b0);
    do_req(1'b1, 1'b1, 32'd10,         32'hDEADBEEF,  1'b0, 32'd5,         1'b0);
    do_req(1'b1, 1'b0, 32'd10,         32'h0,         1'b0, 32'hDEADBEEF,  1'b0);
    do_req(1'b0, 1'b1, 32'd128,        32'h1111_2222, 1'b1, 32'hDEADBEEF,  1'b0);
    do_req(1'b0, 1'b0, 32'hFFFF_FFFF,  32'h0,         1'b1, 32'hDEADBEEF,  1'b0);
    do_req(1'b0, 1'b1, 32'd127,        32'h1234_5678, 1'b0, 32'hDEADBEEF,  1'b0);
    do_req(1'b1, 1'b0, 32'd127,        32'h0,         1'b0, 32'h1234_5678, 1'b0);
    do_req(1'b0, 1'b0, 32'd5,          32'h0,         1'b0, 32'd5,         1'b1);

    // Reset during the ACCESS cycle of a read: grant seen, no ack
    g.p = 1'b1; g.we = 1'b0; g.re = 1'b1; g.chk_addr = 1'b1; g.addr = 32'd2; g.wd = 32'h0;
    gq.push_back(g);
    bus.req1 = 1'b1; bus.wr1 = 1'b0; bus.addr1 = 32'd2;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (bus.gnt1) break;
    end
    RST = 1'b1;
    chk_reset = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk_reset = 1'b0;
    bus.req1 = 1'b0; bus.addr1 = 32'h0;
    repeat (3) @(negedge CLK);

    do_req(1'b0, 1'b0, 32'd1, 32'h0, 1'b0, 32'd1, 1'b0);

    end_chk = 1'b1;
    @(negedge CLK);
    end_chk = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
